sram_port_arbiter: RTL
======================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max consecutive data grants while an instruction request waits (legal 1-15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports inst_req  input  1, inst_addr  input  32: fetch request and word address (read only).
REQ-005 SHALL have ports inst_gnt  output  1, inst_done  output  1, inst_rdata  output  32: grant, response valid, fetched word.
REQ-006 SHALL have ports data_req  input  1, data_wen  input  4, data_addr  input  32, data_wdata  input  32: load/store request; data_wen==0 means read.
REQ-007 SHALL have ports data_gnt  output  1, data_done  output  1, data_rdata  output  32: grant, response valid, load word.
REQ-008 SHALL have ports sram_en  output  1, sram_wen  output  4, sram_addr  output  32, sram_wdata  output  32, sram_rdata  input  32: shared single-port SRAM, fixed 1-cycle read latency.
REQ-009 SHALL have port stallreq_for_mem  output  1: pipeline stall request to the stall controller.

Function
REQ-010 Requesters SHALL hold req, addr, wen, wdata stable from assertion until the cycle their gnt is 1; arbiter SHALL NOT depend on values after grant.
REQ-011 At most one grant SHALL be issued per cycle; inst_gnt and data_gnt SHALL never be 1 together.
REQ-012 Grant SHALL be combinational in the request cycle: the granted requester's addr/wen/wdata drive sram_* the same cycle with sram_en=1; no grant -> sram_en=0, sram_wen=0.
REQ-013 inst grant SHALL drive sram_wen=0 regardless of other inputs.
REQ-014 Priority: data over inst, except when starve_cnt==STARVE_LIMIT and inst_req=1, then inst SHALL be granted.
REQ-015 starve_cnt (4 bits): increments on data grant while inst_req=1 and inst not granted; clears on inst grant or when inst_req=0; saturates at STARVE_LIMIT.
REQ-016 Owner register SHALL take states NONE, INST, DATA: next = INST on inst_gnt, DATA on data_gnt, else NONE.
REQ-017 Owner INST -> inst_done=1 and inst_rdata=sram_rdata that cycle; owner DATA -> data_done=1, data_rdata=sram_rdata (meaningful for reads only); owner NONE -> both done=0.
REQ-018 done SHALL occur exactly 1 cycle after gnt for reads and writes; back-to-back grants SHALL yield back-to-back dones (full throughput, one access per cycle).
REQ-019 rdata outputs SHALL be 0 when the corresponding done is 0.
REQ-020 stallreq_for_mem SHALL be 1 in any cycle where (inst_req & ~inst_gnt) | (data_req & ~data_gnt); combinational.
REQ-021 Requests with req=0 SHALL never be granted; idle cycle leaves owner NONE next cycle.

Reset
REQ-022 While rst=1: owner=NONE, starve_cnt=0, all gnt, done, sram_en, sram_wen, stallreq_for_mem SHALL be 0 and rdata outputs 0.
REQ-023 A grant issued in the cycle before rst is sampled SHALL produce no done in the reset cycle (owner cleared by reset).
REQ-024 First grant possible in the first cycle with rst=0.

Verification
REQ-025 Single read: data_req=1, data_wen=0, addr=0x100, SRAM word 0xDEADBEEF -> data_gnt=1 cycle 0, data_done=1, data_rdata=0xDEADBEEF cycle 1, stallreq=0.
REQ-026 Collision: inst_req and data_req (store, wen=0xF, wdata=0x12345678) same cycle -> data granted cycle 0, stallreq=1, inst granted cycle 1, inst_done cycle 2 with fetched word.
REQ-027 Starvation: inst_req held, data_req held 8 cycles, STARVE_LIMIT=4 -> data grants cycles 0-3, inst grant cycle 4, starve_cnt=0 after, data resumes cycle 5.
REQ-028 Streaming: inst_req held 4 cycles, addrs 0x0,0x4,0x8,0xC -> inst_done cycles 1-4 with matching words, no bubbles.
REQ-029 Reset mid-op: data read granted cycle 5, rst=1 cycle 6 -> data_done=0 cycle 6, all outputs 0, normal grant cycle 7 after rst=0.
REQ-030 Exclusivity check: random req/wen stimulus 10k cycles -> never both gnt, done always 1 cycle after matching gnt, sram_wen=0 on every inst grant.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-port SRAM (1-cycle read latency) between an instruction
// fetch port and a load/store port. Grants are combinational in the request
// cycle, and the response (done/rdata) comes back exactly one cycle later.
// Data accesses normally win. An instruction fetch that keeps losing is
// forced through after STARVE_LIMIT consecutive data grants.
//
// owner state | meaning
// ------------+-------------------------------------------------------------
// OWN_NONE    | no access was issued last cycle; both done outputs low
// OWN_INST    | last cycle's access was a fetch; sram_rdata belongs to inst
// OWN_DATA    | last cycle's access was a load/store; sram_rdata to data port
module sram_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_gnt,
   output logic        inst_done,
   output logic [31:0] inst_rdata,

   input  logic        data_req,
   input  logic [3:0]  data_wen,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_gnt,
   output logic        data_done,
   output logic [31:0] data_rdata,

   output logic        sram_en,
   output logic [3:0]  sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,

   output logic        stallreq_for_mem
);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_INST = 2'd1;
   localparam logic [1:0] OWN_DATA = 2'd2;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [1:0] owner_q,      owner_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic       inst_win;

   // Grant decision: data first unless the fetch has waited out its budget.
   // Reset blocks every grant so nothing reaches the SRAM during reset.
   always_comb begin
      inst_win = inst_req & (~data_req | (starve_cnt_q == STARVE_MAX));
      inst_gnt = ~rst & inst_win;
      data_gnt = ~rst & data_req & ~inst_win;
   end

   // Steer the granted port onto the SRAM; fetches never write.
   always_comb begin
      sram_en    = 1'b0;
      sram_wen   = 4'h0;
      sram_addr  = 32'h0;
      sram_wdata = 32'h0;
      if (inst_gnt) begin
         sram_en   = 1'b1;
         sram_addr = inst_addr;
      end else if (data_gnt) begin
         sram_en    = 1'b1;
         sram_wen   = data_wen;
         sram_addr  = data_addr;
         sram_wdata = data_wdata;
      end
   end

   // Any waiting request that did not get the SRAM this cycle stalls the pipe.
   always_comb begin
      stallreq_for_mem = ~rst & ((inst_req & ~inst_gnt) | (data_req & ~data_gnt));
   end

   // Next owner and starvation count.
   always_comb begin
      owner_d = OWN_NONE;
      if (inst_gnt) begin
         owner_d = OWN_INST;
      end else if (data_gnt) begin
         owner_d = OWN_DATA;
      end

      starve_cnt_d = starve_cnt_q;
      if (~inst_req | inst_gnt) begin
         starve_cnt_d = 4'h0;
      end else if (data_gnt && (starve_cnt_q != STARVE_MAX)) begin
         starve_cnt_d = starve_cnt_q + 4'h1;
      end
   end

   // Route the SRAM read data to whichever port owned last cycle's access.
   // Reset masks a response still in flight from the cycle before reset.
   always_comb begin
      inst_done  = ~rst & (owner_q == OWN_INST);
      data_done  = ~rst & (owner_q == OWN_DATA);
      inst_rdata = inst_done ? sram_rdata : 32'h0;
      data_rdata = data_done ? sram_rdata : 32'h0;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q      <= OWN_NONE;
         starve_cnt_q <= 4'h0;
      end else begin
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule
